// File: rtl/sd_track_pkg.sv
// Shared types for the multi-drive track cache: FSM states, transfer direction, LBA width.
package sd_track_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_e;
  typedef enum logic {MODE_READ, MODE_WRITE} mode_e;
  localparam int LBA_W = 32;
endpackage

// File: rtl/sd_rr_arbiter.sv
// Round-robin arbiter: searches from i_ptr+1 and grants the first requester; purely combinational.
module sd_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/sd_track_cache.sv
// Track-buffer manager: write back dirty tracks, reload on track change/mount, one SD channel at a time.
// One cycle from need to request; the CPU is stalled for the whole transfer, hps_io paces via sd_ack.
module sd_track_cache
  import sd_track_pkg::*;
#(
  parameter int NUM_DRIVES        = 2,
  parameter int SECTORS_PER_TRACK = 13,
  parameter int TRACK_W           = 6,
  parameter int SEC_W             = (SECTORS_PER_TRACK > 1) ? $clog2(SECTORS_PER_TRACK) : 1,
  parameter int DRV_W             = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                          clk_sys,
  input  logic                          nRESET,
  input  logic [NUM_DRIVES*TRACK_W-1:0] track,
  input  logic [NUM_DRIVES-1:0]         disk_we,
  input  logic [NUM_DRIVES-1:0]         img_mounted,
  input  logic [NUM_DRIVES-1:0]         img_present,
  input  logic                          img_readonly,
  output logic [NUM_DRIVES*LBA_W-1:0]   sd_lba,
  output logic [NUM_DRIVES-1:0]         sd_rd,
  output logic [NUM_DRIVES-1:0]         sd_wr,
  input  logic [NUM_DRIVES-1:0]         sd_ack,
  output logic [DRV_W-1:0]              buf_drive,
  output logic [SEC_W-1:0]              buf_sec,
  output logic                          cpu_wait,
  output logic [NUM_DRIVES-1:0]         busy
);
  state_e                 r_state, w_state_nx;
  mode_e                  r_mode;
  logic [DRV_W-1:0]       r_drv, r_ptr, w_idx;
  logic [SEC_W-1:0]       r_sec;
  logic [LBA_W-1:0]       r_base;
  logic                   r_cpu_wait;
  logic [NUM_DRIVES-1:0]  r_busy, r_old_ack;
  logic [NUM_DRIVES-1:0]  r_valid, r_dirty, r_protect, r_present;
  logic [TRACK_W-1:0]     r_cur [NUM_DRIVES];
  logic [TRACK_W-1:0]     w_trk [NUM_DRIVES];
  logic [NUM_DRIVES-1:0]  w_wb_need, w_rd_need, w_need, w_need_done, w_gnt;
  logic                   w_any, w_grant, w_sec_inc, w_done, w_gnt_wr;
  logic                   w_ack_rise, w_ack_fall;
  logic [TRACK_W-1:0]     w_gnt_trk;

  assign w_need     = w_wb_need | w_rd_need;
  assign w_ack_rise = sd_ack[r_drv] & ~r_old_ack[r_drv];
  assign w_ack_fall = ~sd_ack[r_drv] & r_old_ack[r_drv];
  assign w_gnt_wr   = w_wb_need[w_idx];
  // A write-back addresses the track still held in the buffer, a read the newly requested one.
  assign w_gnt_trk  = w_gnt_wr ? r_cur[w_idx] : w_trk[w_idx];

  sd_rr_arbiter #(.N(NUM_DRIVES), .IDX_W(DRV_W)) u_arb (
    .i_req (w_need),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_drv
    logic w_this;
    assign w_this       = (r_drv == DRV_W'(g));
    assign w_trk[g]     = track[g*TRACK_W +: TRACK_W];
    assign w_wb_need[g] = r_valid[g] & r_dirty[g] & (w_trk[g] != r_cur[g]);
    assign w_rd_need[g] = r_present[g] & (~r_valid[g] | (w_trk[g] != r_cur[g]));

    always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
        r_valid[g]   <= 1'b0;
        r_dirty[g]   <= 1'b0;
        r_protect[g] <= 1'b0;
        r_present[g] <= 1'b0;
        r_cur[g]     <= '0;
      end else begin
        if (w_grant && w_gnt[g] && !w_gnt_wr) r_cur[g] <= w_trk[g];
        if (img_mounted[g]) begin
          r_valid[g]   <= 1'b0;
          r_protect[g] <= img_readonly;
          r_present[g] <= img_present[g];
        end else if (w_grant && w_gnt[g] && !w_gnt_wr) begin
          r_valid[g] <= 1'b0;
        end else if (w_done && w_this && r_mode == MODE_READ && r_present[g]) begin
          r_valid[g] <= 1'b1;
        end
        if (disk_we[g] && !r_protect[g])
          r_dirty[g] <= 1'b1;
        else if (img_mounted[g] || (w_done && w_this && r_mode == MODE_WRITE))
          r_dirty[g] <= 1'b0;
      end
    end
  end

  // Needs as they will stand once this DONE cycle's flag updates land.
  always_comb begin
    w_need_done = w_need;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (r_drv == DRV_W'(i)) begin
        if (r_mode == MODE_WRITE)
          w_need_done[i] = w_rd_need[i] | (w_wb_need[i] & disk_we[i] & ~r_protect[i]);
        else
          w_need_done[i] = r_present[i] & (w_trk[i] != r_cur[i]);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant    = 1'b0;
    w_sec_inc  = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) begin
        w_grant    = 1'b1;
        w_state_nx = ST_REQ;
      end
      ST_REQ: if (w_ack_rise) w_state_nx = ST_XFER;
      ST_XFER: if (w_ack_fall) begin
        if (r_sec == SEC_W'(SECTORS_PER_TRACK - 1) || !r_present[r_drv]) begin
          w_state_nx = ST_DONE;
        end else begin
          w_sec_inc  = 1'b1;
          w_state_nx = ST_REQ;
        end
      end
      ST_DONE: begin
        w_done     = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      r_mode     <= MODE_READ;
      r_drv      <= '0;
      r_ptr      <= '0;
      r_sec      <= '0;
      r_base     <= '0;
      r_cpu_wait <= 1'b0;
      r_busy     <= '0;
      r_old_ack  <= '0;
    end else begin
      r_old_ack <= sd_ack;
      if (w_grant) begin
        r_drv      <= w_idx;
        r_mode     <= w_gnt_wr ? MODE_WRITE : MODE_READ;
        r_base     <= LBA_W'(SECTORS_PER_TRACK) * LBA_W'(w_gnt_trk);
        r_sec      <= '0;
        r_cpu_wait <= 1'b1;
        r_busy     <= r_busy | w_gnt;
      end
      if (w_sec_inc) r_sec <= r_sec + 1'b1;
      if (w_done) begin
        r_busy[r_drv] <= 1'b0;
        r_ptr         <= r_drv;
        r_cpu_wait    <= |w_need_done;
      end
    end
  end

  always_comb begin
    sd_rd  = '0;
    sd_wr  = '0;
    sd_lba = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      sd_rd[i] = (r_state == ST_REQ) && (r_drv == DRV_W'(i)) && (r_mode == MODE_READ);
      sd_wr[i] = (r_state == ST_REQ) && (r_drv == DRV_W'(i)) && (r_mode == MODE_WRITE);
      sd_lba[i*LBA_W +: LBA_W] = r_busy[i] ? (r_base + LBA_W'(r_sec)) : '0;
    end
  end

  assign buf_drive = r_drv;
  assign buf_sec   = r_sec;
  assign cpu_wait  = r_cpu_wait;
  assign busy      = r_busy;
endmodule

// File: doc/sd_track_cache.md
Name: sd_track_cache

Overview:
- Multi-drive track-buffer manager between the disk controllers and the hps_io virtual-disk channels; a parametrised successor to the single-drive, read-only floppy track loader.
- Per drive, it detects a track change or image mount and fills the track buffer from the SD image.
- New: dirty-track write-back before reload, write-protect handling, round-robin arbitration across NUM_DRIVES channels, and a CPU wait held for the whole transfer.

Parameters:
NUM_DRIVES, 2, number of virtual disk channels served
SECTORS_PER_TRACK, 13, 512-byte SD sectors per track buffer
TRACK_W, 6, width of each drive's track number
SEC_W, $clog2(SECTORS_PER_TRACK), derived; width of buffer sector index
DRV_W, max(1,$clog2(NUM_DRIVES)), derived; width of drive index

Ports:
clk_sys  in  1  system clock; all logic on rising edge
nRESET  in  1  reset, asynchronous assert, active-low
track  in  NUM_DRIVES*TRACK_W  requested track per drive, level
disk_we  in  NUM_DRIVES  one-cycle strobe: controller wrote drive i's track buffer
img_mounted  in  NUM_DRIVES  one-cycle mount/unmount strobe from hps_io
img_present  in  NUM_DRIVES  level: image size nonzero, sampled on img_mounted
img_readonly  in  1  sampled with img_mounted
sd_lba  out  NUM_DRIVES*32  LBA per drive
sd_rd  out  NUM_DRIVES  read request per drive
sd_wr  out  NUM_DRIVES  write request per drive
sd_ack  in  NUM_DRIVES  hps_io acknowledge per drive
buf_drive  out  DRV_W  drive owning current transfer
buf_sec  out  SEC_W  sector index; buffer address = {buf_drive, buf_sec, sd_buff_addr}
cpu_wait  out  1  stall request to CPU
busy  out  NUM_DRIVES  drive i is mid-transfer

Behaviour:
- Reset:
  - All outputs 0.
  - Per drive: valid=0, dirty=0, protect=0, cur_track=0.
  - FSM in IDLE; round-robin pointer = 0.
- Per-drive flags:
  - img_mounted[i]: valid<=0, dirty<=0, protect<=img_readonly, present<=img_present[i].
  - disk_we[i]: dirty<=1 unless protect. A set beats a clear in the same cycle.
- Need, for drive i:
  - wb_need = valid & dirty & (track!=cur_track).
  - rd_need = present & (~valid | track!=cur_track).
- FSM states: IDLE, REQ, XFER, DONE.
  - IDLE: round-robin from pointer+1; first drive with wb_need|rd_need is granted (combinational arbiter, one-cycle grant). Mode = WRITE if wb_need, else READ. On a READ grant, latch cur_track<=track. LBA base = SECTORS_PER_TRACK*cur_track (WRITE uses the old cur_track). buf_sec<=0, cpu_wait<=1, busy[i]<=1, go to REQ.
  - REQ: drive sd_rd[i] or sd_wr[i] = 1, sd_lba[i] = base+buf_sec. On sd_ack[i] rise, drop request, go to XFER.
  - XFER: on sd_ack[i] fall:
    - If buf_sec==SECTORS_PER_TRACK-1, go to DONE.
    - Otherwise buf_sec+1, go to REQ.
  - DONE:
    - WRITE: dirty<=0 (unless set by disk_we this cycle); return to IDLE. rd_need is re-evaluated, so the reload follows next arbitration.
    - READ: valid<=1.
    - Both: busy[i]<=0, pointer<=i. cpu_wait<=0 only if no drive has any need, else stays 1.
- Latency: one cycle from need to request; no dead cycle between sectors beyond the ack edge detect (registered old_ack).
- Track changes while busy: the new value is seen at the next IDLE, which triggers a further transfer.
- Unmount (img_mounted with img_present=0) of the active drive: finish the current sector handshake, then go to DONE without setting valid.
- Arithmetic: LBA is 32-bit unsigned, base = track*SECTORS_PER_TRACK zero-extended; no wrap checks.
- Reset mid-transfer: all requests drop immediately and asynchronously; no partial write is retried.

Decomposition:
- Package sd_track_pkg: FSM state enum, mode enum (READ/WRITE), LBA_W=32.
- Sub-module sd_rr_arbiter (NUM_DRIVES request vector + pointer -> one-hot grant + index).
- Per-drive flag registers stay in the top module, using a generate loop.

Test Plan:
1. Mount drive 0 (present=1, readonly=0), track=0 -> sd_rd[0] pulses 13 times, LBA 0..12, buf_sec 0..12; cpu_wait high throughout, low one cycle after DONE; valid set.
2. Drive 0 valid on track 3, disk_we[0] pulse, then track=4 -> sd_wr[0] LBA 39..51, then sd_rd[0] LBA 52..64; cpu_wait continuously high; dirty ends 0.
3. Readonly mount on drive 1, disk_we[1], track change 0->1 -> no sd_wr; only sd_rd LBA 13..25.
4. Drives 0 and 1 request in the same cycle with pointer=0 -> drive 1 served first, then drive 0; never both sd_rd bits high.
5. nRESET low during REQ with sd_rd[0]=1 -> sd_rd, cpu_wait, busy go 0 asynchronously; after release, drive 0 reloads from sector 0.
6. Unmount drive 0 mid-XFER -> current sector completes, no further requests, valid=0, cpu_wait drops.
